math_sub_48: RTL



---
 rtl/math_pkg.sv | 16 +
 rtl/math_sub_split_stage.sv | 25 ++
 rtl/math_sub_48.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/math_pkg.sv
// Shared constants for the math datapath blocks (adder/subtractor family).
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package math_pkg;

  localparam int MATH_W           = 48;
  localparam int MATH_SUB_LAT     = 2;
  localparam int MATH_SUB_SAT_LAT = 3;

  // DSP48E1 control words: P = Z - (X + Y + CIN), X = A:B, Y = 0, Z = C
  localparam logic [3:0] ALU_SUB_ZXY = 4'b0011;
  localparam logic [6:0] OPM_C_AB    = 7'b0110011;
  // A and B taken straight from their input registers, no pre-adder
  localparam logic [4:0] INM_A_B     = 5'b00000;

endpackage

// File: rtl/math_sub_split_stage.sv
// One registered N-bit subtract with borrow-in, result {borrow_out, diff}.
// Latency: 1 enabled cycle.
// Backpressure: none; ena=0 holds the register, rst clears it (rst wins).
module math_sub_split_stage #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N:0]   d
);

  // Extending both operands by one zero bit makes d[N] the borrow out.
  always_ff @(posedge clk) begin
    if (rst) begin
      d <= '0;
    end else if (ena) begin
      d <= {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    end
  end

endmodule

// File: rtl/math_sub_48.sv
// 48-bit unsigned subtractor dout = {borrow, dina - dinb}; DSP48E1 style or fabric split-carry.
// Latency: 2 enabled cycles (3 with MATH_SUB_48_SAT_EN, which also clamps the difference to 0 on borrow).
// Backpressure: none; ena=0 freezes every stage including the valid pipe, rst clears all (rst wins).
module math_sub_48
  import math_pkg::*;
#(
  parameter int USE_FABRIC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_valid,
  input  logic [MATH_W-1:0] dina,
  input  logic [MATH_W-1:0] dinb,
  output logic              out_valid,
  output logic [MATH_W:0]   dout
);

`ifdef MATH_SUB_48_SAT_EN
  localparam int LAT = MATH_SUB_SAT_LAT;
`else
  localparam int LAT = MATH_SUB_LAT;
`endif

  // Two-stage difference {borrow, diff}, registered in both implementations
  logic [MATH_W:0] diff_q;

  generate
    if (USE_FABRIC != 0) begin : g_fabric
      localparam int H = MATH_W / 2;

      logic [H:0]   lo_q;
      logic [H:0]   hi_q;
      logic [H-1:0] a_hi_q;
      logic [H-1:0] b_hi_q;
      logic [H-1:0] lo_dly_q;

      // Low half subtracts first; its borrow feeds the high half one cycle later.
      math_sub_split_stage #(.N(H)) u_lo (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .a   (dina[H-1:0]),
        .b   (dinb[H-1:0]),
        .bin (1'b0),
        .d   (lo_q)
      );

      // Hold the upper operand halves so they line up with the low-half borrow.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_hi_q <= '0;
          b_hi_q <= '0;
        end else if (ena) begin
          a_hi_q <= dina[MATH_W-1:H];
          b_hi_q <= dinb[MATH_W-1:H];
        end
      end

      math_sub_split_stage #(.N(H)) u_hi (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .a   (a_hi_q),
        .b   (b_hi_q),
        .bin (lo_q[H]),
        .d   (hi_q)
      );

      // Delay the low-half result so both halves leave together.
      always_ff @(posedge clk) begin
        if (rst) begin
          lo_dly_q <= '0;
        end else if (ena) begin
          lo_dly_q <= lo_q[H-1:0];
        end
      end

      assign diff_q = {hi_q, lo_dly_q};

    end else begin : g_dsp
      // Behavioural DSP48E1 slice: AREG=BREG=CREG=1, MREG=0, PREG=1.
      logic [29:0]       a_q;
      logic [17:0]       b_q;
      logic [MATH_W-1:0] c_q;
      logic [MATH_W-1:0] x_mux;
      logic [MATH_W-1:0] z_mux;
      logic [MATH_W:0]   alu_sum;
      logic [MATH_W-1:0] p_q;
      logic              borrow_q;

      // Input registers: subtrahend on A:B, minuend on C.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= '0;
        end else if (ena) begin
          a_q <= dinb[MATH_W-1:18];
          b_q <= dinb[17:0];
          c_q <= dina;
        end
      end

      // Fixed control words select X=A:B, Y=0, Z=C; CARRYIN is tied low.
      always_comb begin
        x_mux = '0;
        z_mux = '0;
        if (OPM_C_AB[1:0] == 2'b11 && INM_A_B == 5'b00000) x_mux = {a_q, b_q};
        if (OPM_C_AB[6:4] == 3'b011) z_mux = c_q;
        if (ALU_SUB_ZXY == 4'b0011) begin
          // Z - X computed as Z + ~X + 1; carry out is high when no borrow occurs
          alu_sum = {1'b0, z_mux} + {1'b0, ~x_mux} + {{MATH_W{1'b0}}, 1'b1};
        end else begin
          alu_sum = {1'b0, z_mux} + {1'b0, x_mux};
        end
      end

      // P register; CARRYOUT[3] is inverted before storage so reset reads as no borrow.
      always_ff @(posedge clk) begin
        if (rst) begin
          p_q      <= '0;
          borrow_q <= 1'b0;
        end else if (ena) begin
          p_q      <= alu_sum[MATH_W-1:0];
          borrow_q <= ~alu_sum[MATH_W];
        end
      end

      assign diff_q = {borrow_q, p_q};
    end
  endgenerate

`ifdef MATH_SUB_48_SAT_EN
  // Extra output stage: clamp the magnitude to zero whenever the result borrowed.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (ena) begin
      dout <= diff_q[MATH_W] ? {1'b1, {MATH_W{1'b0}}} : diff_q;
    end
  end
`else
  assign dout = diff_q;
`endif

  // Valid shift register tracks the data latency and stalls with it.
  logic [LAT-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (ena) begin
      vld_pipe <= {vld_pipe[LAT-2:0], in_valid};
    end
  end

  assign out_valid = vld_pipe[LAT-1];

endmodule
